// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    localparam int DMEM_DATA_W  = 16;
    localparam int DMEM_LAT_MAX = 15;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, asynchronous read.
// It has no reset, so its contents survive a reset of the responder.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [DMEM_DATA_W-1:0] i_wdata,
    output logic [DMEM_DATA_W-1:0] o_rdata
);

    logic [DMEM_DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with a fixed wait latency.
// It stalls the pipeline via o_mem_busy until the access completes.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LAT    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_r,
    input  logic        i_mem_w,
    input  logic [15:0] i_ls_addr,
    input  logic [15:0] i_store_data,
    output logic        o_mem_busy,
    output logic [15:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_wr_done,
    output logic        o_err,
    output logic [15:0] o_rd_count,
    output logic [15:0] o_wr_count
);

    state_t      r_state;
    op_t         r_op;
    logic [3:0]  r_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rd_data;
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;
    logic        r_err;
    logic        r_rd_valid;
    logic        r_wr_done;

    logic        w_req;
    logic        w_accept;
    logic        w_enter_resp;
    logic        w_is_wr;
    logic        w_in_range;
    logic        w_we;
    logic [15:0] w_addr;
    logic [15:0] w_wdata;
    logic [15:0] w_arr_rdata;

    assign w_req    = i_mem_r | i_mem_w;
    assign w_accept = (r_state == IDLE) && w_req;

    // With LAT=0 the access completes on the accepting edge, so the live
    // request inputs must drive the array instead of the latched copies.
    assign w_addr       = (r_state == IDLE) ? i_ls_addr    : r_addr;
    assign w_wdata      = (r_state == IDLE) ? i_store_data : r_wdata;
    assign w_is_wr      = (r_state == IDLE) ? i_mem_w      : (r_op == OP_WR);
    assign w_in_range   = (w_addr[15:ADDR_W] == '0);
    assign w_enter_resp = ((r_state == WAIT) && (r_cnt == 4'd0)) || (w_accept && (LAT == 0));
    assign w_we         = w_enter_resp && w_is_wr && w_in_range;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_addr  (w_addr[ADDR_W-1:0]),
        .i_wdata (w_wdata),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_op       <= OP_RD;
            r_cnt      <= 4'd0;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_rd_data  <= 16'h0000;
            r_rd_count <= 16'h0000;
            r_wr_count <= 16'h0000;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_wr_done  <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_wr_done  <= 1'b0;
            if (w_enter_resp) begin
                if (w_is_wr) begin
                    r_wr_done <= 1'b1;
                end else begin
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= w_in_range ? w_arr_rdata : 16'h0000;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr  <= i_ls_addr;
                        r_wdata <= i_store_data;
                        r_op    <= i_mem_w ? OP_WR : OP_RD;
                        if ((i_mem_r && i_mem_w) || !w_in_range) begin
                            r_err <= 1'b1;
                        end
                        if (LAT == 0) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= 4'(LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    if (r_op == OP_WR) begin
                        r_wr_count <= r_wr_count + 16'd1;
                    end else begin
                        r_rd_count <= r_rd_count + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mem_busy = w_accept || (r_state == WAIT);
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_wr_done  = r_wr_done;
    assign o_err      = r_err;
    assign o_rd_count = r_rd_count;
    assign o_wr_count = r_wr_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance 0 runs with LAT=2, instance 1 with LAT=0.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [1:0]  mr;
    logic [1:0]  mw;
    logic [15:0] addr;
    logic [15:0] sdat;
    logic [1:0]  busy;
    logic [1:0]  rv;
    logic [1:0]  wd;
    logic [1:0]  er;
    logic [15:0] rdd [2];
    logic [15:0] rcnt [2];
    logic [15:0] wcnt [2];

    int checks = 0;
    int errors = 0;

    dmem_responder #(.ADDR_W(8), .LAT(2)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_mem_r(mr[0]), .i_mem_w(mw[0]),
        .i_ls_addr(addr), .i_store_data(sdat), .o_mem_busy(busy[0]),
        .o_rd_data(rdd[0]), .o_rd_valid(rv[0]), .o_wr_done(wd[0]), .o_err(er[0]),
        .o_rd_count(rcnt[0]), .o_wr_count(wcnt[0])
    );

    dmem_responder #(.ADDR_W(8), .LAT(0)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_mem_r(mr[1]), .i_mem_w(mw[1]),
        .i_ls_addr(addr), .i_store_data(sdat), .o_mem_busy(busy[1]),
        .o_rd_data(rdd[1]), .o_rd_valid(rv[1]), .o_wr_done(wd[1]), .o_err(er[1]),
        .o_rd_count(rcnt[1]), .o_wr_count(wcnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;
        logic        r;
        logic        w;
        logic [15:0] a;
        logic [15:0] data;
        logic [15:0] exp_rd;
        logic [15:0] exp_rc;
        logic [15:0] exp_wc;
        logic        exp_err;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input logic r, input logic w, input logic [15:0] a,
                                input logic [15:0] data, input logic [15:0] exp_rd,
                                input logic [15:0] rc, input logic [15:0] wc, input logic e);
        vec_t v;
        v.d = d; v.r = r; v.w = w; v.a = a; v.data = data; v.exp_rd = exp_rd;
        v.exp_rc = rc; v.exp_wc = wc; v.exp_err = e;
        return v;
    endfunction

    // Called at posedge+1; runs one access to completion, checking every cycle.
    task automatic run(input vec_t v);
        int lat;
        bit is_rd;
        lat   = (v.d == 0) ? 2 : 0;
        is_rd = v.r && !v.w;
        mr[v.d] = v.r;
        mw[v.d] = v.w;
        addr    = v.a;
        sdat    = v.data;
        for (int c = 0; c <= lat + 1; c++) begin
            @(negedge clk);
            check($sformatf("busy d%0d c%0d", v.d, c), 16'(busy[v.d]), 16'(c <= lat));
            check($sformatf("rd_valid d%0d c%0d", v.d, c), 16'(rv[v.d]), 16'(is_rd && c == lat + 1));
            check($sformatf("wr_done d%0d c%0d", v.d, c), 16'(wd[v.d]), 16'(!is_rd && c == lat + 1));
            if (is_rd && c == lat + 1)
                check($sformatf("rd_data d%0d a%h", v.d, v.a), rdd[v.d], v.exp_rd);
            @(posedge clk);
            #1;
        end
        mr[v.d] = 1'b0;
        mw[v.d] = 1'b0;
        check($sformatf("rd_count d%0d", v.d), rcnt[v.d], v.exp_rc);
        check($sformatf("wr_count d%0d", v.d), wcnt[v.d], v.exp_wc);
        check($sformatf("err d%0d", v.d), 16'(er[v.d]), 16'(v.exp_err));
        $display("txn d%0d r%0b w%0b addr %h data %h rd_data %h rc %0d wc %0d err %0b",
                 v.d, v.r, v.w, v.a, v.data, rdd[v.d], rcnt[v.d], wcnt[v.d], er[v.d]);
    endtask

    task automatic check_zero(input int d);
        check($sformatf("rst busy d%0d", d), 16'(busy[d]), 16'd0);
        check($sformatf("rst rd_data d%0d", d), rdd[d], 16'd0);
        check($sformatf("rst rd_valid d%0d", d), 16'(rv[d]), 16'd0);
        check($sformatf("rst wr_done d%0d", d), 16'(wd[d]), 16'd0);
        check($sformatf("rst err d%0d", d), 16'(er[d]), 16'd0);
        check($sformatf("rst rd_count d%0d", d), rcnt[d], 16'd0);
        check($sformatf("rst wr_count d%0d", d), wcnt[d], 16'd0);
    endtask

    initial begin
        rst = 1'b1; mr = 2'b00; mw = 2'b00; addr = 16'h0000; sdat = 16'h0000;

        //            d  r  w  addr     data     exp_rd   rc  wc  err
        tbl[0]  = mk(0, 0, 1, 16'h0000, 16'h0F0F, 16'h0000, 0, 1, 0);
        tbl[1]  = mk(0, 0, 1, 16'h0007, 16'h1357, 16'h0000, 0, 2, 0);
        tbl[2]  = mk(0, 0, 1, 16'h0005, 16'hBEEF, 16'h0000, 0, 3, 0);
        tbl[3]  = mk(0, 1, 0, 16'h0005, 16'h0000, 16'hBEEF, 1, 3, 0);
        tbl[4]  = mk(0, 1, 1, 16'h0010, 16'h1234, 16'h0000, 1, 4, 1);
        tbl[5]  = mk(0, 1, 0, 16'h0010, 16'h0000, 16'h1234, 2, 4, 1);
        tbl[6]  = mk(0, 0, 1, 16'h0100, 16'hAAAA, 16'h0000, 2, 5, 1);
        tbl[7]  = mk(0, 1, 0, 16'h0000, 16'h0000, 16'h0F0F, 3, 5, 1);
        tbl[8]  = mk(0, 1, 0, 16'h0100, 16'h0000, 16'h0000, 4, 5, 1);
        tbl[9]  = mk(1, 0, 1, 16'h0000, 16'h0011, 16'h0000, 0, 1, 0);
        tbl[10] = mk(1, 1, 0, 16'h0000, 16'h0000, 16'h0011, 1, 1, 0);
        tbl[11] = mk(1, 0, 1, 16'h0001, 16'h0022, 16'h0000, 1, 2, 0);
        tbl[12] = mk(1, 1, 0, 16'h0001, 16'h0000, 16'h0022, 2, 2, 0);
        tbl[13] = mk(1, 0, 1, 16'h0002, 16'h0033, 16'h0000, 2, 3, 0);
        tbl[14] = mk(1, 1, 0, 16'h0002, 16'h0000, 16'h0033, 3, 3, 0);
        tbl[15] = mk(1, 0, 1, 16'h0003, 16'h0044, 16'h0000, 3, 4, 0);
        tbl[16] = mk(1, 1, 0, 16'h0003, 16'h0000, 16'h0044, 4, 4, 0);

        #1;
        check_zero(0);
        check_zero(1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) run(tbl[i]);

        // Reset during WAIT of a write: outputs clear at once, write is lost.
        mw[0] = 1'b1; addr = 16'h0007; sdat = 16'h5555;
        @(posedge clk); #1;
        @(negedge clk);
        check("wait busy", 16'(busy[0]), 16'd1);
        @(posedge clk); #1;
        mw[0] = 1'b0;
        rst   = 1'b1;
        #1;
        check_zero(0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run(mk(0, 1, 0, 16'h0007, 16'h0000, 16'h1357, 1, 0, 0));
        run(mk(0, 1, 0, 16'h0005, 16'h0000, 16'hBEEF, 2, 0, 0));

        // Read counter wrap from a preset of 0xFFFF.
        force u_dut0.r_rd_count = 16'hFFFF;
        #1;
        release u_dut0.r_rd_count;
        #1;
        run(mk(0, 1, 0, 16'h0010, 16'h0000, 16'h1234, 16'h0000, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
